// File: rtl/cnt_cmd_sequencer.sv
// rtl/cnt_cmd_sequencer.sv - round-robin command sequencer sharing a load/inc/dec counter between two requesters
//
// Purpose: accepts LOAD / UP-by-N / DOWN-by-N commands from requesters A and B
// over valid/ready, arbitrates round-robin, drives the counter controls for the
// required cycles and pulses done_x (with err for reserved or aborted commands).
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   valid_x, cmd_x, arg_x      requester x command (x = a, b)
//   ready_x, done_x            accept strobe (IDLE only), completion pulse
//   abort                      (CNT_SEQ_ABORT_EN only) stop the running command
//   err                        with done_x: reserved command or abort
//   cnt_en, load, inc, d_in    registered counter controls
//   busy                       high outside IDLE
//
// Build option: define CNT_SEQ_ABORT_EN to add the abort input.

module cnt_cmd_sequencer #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_a,
  input  logic [1:0]       cmd_a,
  input  logic [WIDTH-1:0] arg_a,
  output logic             ready_a,
  output logic             done_a,
  input  logic             valid_b,
  input  logic [1:0]       cmd_b,
  input  logic [WIDTH-1:0] arg_b,
  output logic             ready_b,
  output logic             done_b,
`ifdef CNT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             err,
  output logic             cnt_en,
  output logic             load,
  output logic             inc,
  output logic [WIDTH-1:0] d_in,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_RSV  = 2'b11;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;           // 0 = A, 1 = B
  logic              last_grant_q, last_grant_d; // 0 = A, 1 = B
  logic [1:0]        cmd_q, cmd_d;
  logic [STEP_W-1:0] rem_q, rem_d;               // pulses still to issue, including the one on cnt_en now
  logic              err_q, err_d;
  logic              cnt_en_d, load_d, inc_d;
  logic [WIDTH-1:0]  d_in_d;
  logic              abort_req;

  logic              sel_b;
  logic [1:0]        cmd_sel;
  logic [WIDTH-1:0]  arg_sel;
  logic [STEP_W-1:0] n_sel;
  logic              is_step_q;

`ifdef CNT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign is_step_q = (cmd_q == CMD_UP) || (cmd_q == CMD_DOWN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_q        <= CMD_LOAD;
      rem_q        <= '0;
      err_q        <= 1'b0;
      cnt_en       <= 1'b0;
      load         <= 1'b0;
      inc          <= 1'b0;
      d_in         <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
      cnt_en       <= cnt_en_d;
      load         <= load_d;
      inc          <= inc_d;
      d_in         <= d_in_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    rem_d        = rem_q;
    err_d        = err_q;
    cnt_en_d     = 1'b0;
    load_d       = load;
    inc_d        = inc;
    d_in_d       = d_in;
    ready_a      = 1'b0;
    ready_b      = 1'b0;
    sel_b        = 1'b0;
    cmd_sel      = cmd_a;
    arg_sel      = arg_a;
    n_sel        = arg_a[STEP_W-1:0];

    case (state_q)
      S_IDLE: begin
        // reset_n gates ready so it reads 0 while reset is held, like every other output
        ready_a = reset_n & valid_a & (~valid_b | last_grant_q);
        ready_b = reset_n & valid_b & (~valid_a | ~last_grant_q);
        sel_b   = ready_b;
        if (sel_b) begin
          cmd_sel = cmd_b;
          arg_sel = arg_b;
        end
        n_sel = arg_sel[STEP_W-1:0];
        if (ready_a || ready_b) begin
          owner_d      = sel_b;
          last_grant_d = sel_b;
          cmd_d        = cmd_sel;
          rem_d        = n_sel;
          err_d        = (cmd_sel == CMD_RSV);
          state_d      = S_RUN;
          // the first counter pulse is set up on the accept edge so it lands in the first RUN cycle
          case (cmd_sel)
            CMD_LOAD: begin
              cnt_en_d = 1'b1;
              load_d   = 1'b1;
              d_in_d   = arg_sel;
            end
            CMD_UP, CMD_DOWN: begin
              if (n_sel != '0) begin
                cnt_en_d = 1'b1;
                load_d   = 1'b0;
                inc_d    = (cmd_sel == CMD_UP);
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (abort_req) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (is_step_q && (rem_q > STEP_W'(1))) begin
          rem_d    = rem_q - STEP_W'(1);
          cnt_en_d = 1'b1;
        end else begin
          rem_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign done_a = (state_q == S_DONE) & ~owner_q;
  assign done_b = (state_q == S_DONE) & owner_q;
  assign err    = (state_q == S_DONE) & err_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_cnt_cmd_sequencer.sv
// tb/tb_cnt_cmd_sequencer.sv - self-checking bench for cnt_cmd_sequencer

module tb_cnt_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [1:0] cmd_a = 2'b00, cmd_b = 2'b00;
  logic [7:0] arg_a = 8'h00, arg_b = 8'h00;
  logic       ready_a, ready_b, done_a, done_b, err;
  logic       cnt_en, load, inc, busy;
  logic [7:0] d_in;
`ifdef CNT_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  cnt_cmd_sequencer #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .valid_a(valid_a), .cmd_a(cmd_a), .arg_a(arg_a), .ready_a(ready_a), .done_a(done_a),
    .valid_b(valid_b), .cmd_b(cmd_b), .arg_b(arg_b), .ready_b(ready_b), .done_b(done_b),
`ifdef CNT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .err(err), .cnt_en(cnt_en), .load(load), .inc(inc), .d_in(d_in), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted command becomes a list of expected future cycles.
  typedef struct {
    bit       fin;
    bit       en;
    bit       ld;
    bit       up;
    logic [7:0] d;
    bit       own;
    bit       er;
  } rec_t;

  rec_t       q[$];
  bit         lg = 1'b1;
  logic       h_ld = 1'b0, h_up = 1'b0;
  logic [7:0] h_d = 8'h00;

  function automatic rec_t mk(bit fin, bit en, bit ld, bit up, logic [7:0] d, bit own, bit er);
    rec_t r;
    r.fin = fin; r.en = en; r.ld = ld; r.up = up; r.d = d; r.own = own; r.er = er;
    return r;
  endfunction

  function automatic void push_cmd(bit own, logic [1:0] c, logic [7:0] a);
    int n;
    n = int'(a[3:0]);
    case (c)
      2'b00: q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, a, own, 1'b0));
      2'b01, 2'b10: begin
        if (n == 0) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, own, 1'b0));
        else for (int i = 0; i < n; i++) q.push_back(mk(1'b0, 1'b1, 1'b0, c == 2'b01, 8'h00, own, 1'b0));
      end
      default: q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, own, 1'b0));
    endcase
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, own, c == 2'b11));
    lg = own;
  endfunction

  // Observations of the DUT used by the literal checks in the stimulus.
  int         cyc = 0;
  int         acc_a = -1, acc_b = -1, dn_a = -1, dn_b = -1;
  int         en_cnt = 0, busy_gap = 0;
  logic [7:0] en_d = 8'h00;
  logic       en_ld = 1'b0, en_up = 1'b0, dn_err = 1'b0;
  bit         in_cmd = 1'b0;

  rec_t r, r2;
  bit   e_ra, e_rb, e_busy, e_en, e_da, e_db, e_er;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset_n) begin
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_inc", 32'(inc), 32'd0);
        check("rst_d_in", 32'(d_in), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_done_b", 32'(done_b), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        q.delete();
        lg = 1'b1; h_ld = 1'b0; h_up = 1'b0; h_d = 8'h00;
        in_cmd = 1'b0;
      end else begin
        e_ra = 0; e_rb = 0; e_busy = 0; e_en = 0; e_da = 0; e_db = 0; e_er = 0;
        if (q.size() > 0) begin
          r = q.pop_front();
          e_busy = 1'b1;
          if (r.fin) begin
            e_da = !r.own; e_db = r.own; e_er = r.er;
          end else if (r.en) begin
            e_en = 1'b1;
            h_ld = r.ld;
            if (r.ld) h_d = r.d;
            else h_up = r.up;
          end
`ifdef CNT_SEQ_ABORT_EN
          if (abort && !r.fin) begin
            while (q.size() > 0 && !q[0].fin) void'(q.pop_front());
            if (q.size() > 0) begin
              r2 = q.pop_front();
              r2.er = 1'b1;
              q.push_front(r2);
            end
          end
`endif
        end else begin
          e_ra = valid_a && (!valid_b || lg);
          e_rb = valid_b && (!valid_a || !lg);
          if (e_ra) push_cmd(1'b0, cmd_a, arg_a);
          else if (e_rb) push_cmd(1'b1, cmd_b, arg_b);
        end
        check("ready_a", 32'(ready_a), 32'(e_ra));
        check("ready_b", 32'(ready_b), 32'(e_rb));
        check("busy", 32'(busy), 32'(e_busy));
        check("cnt_en", 32'(cnt_en), 32'(e_en));
        check("load", 32'(load), 32'(h_ld));
        check("inc", 32'(inc), 32'(h_up));
        check("d_in", 32'(d_in), 32'(h_d));
        check("done_a", 32'(done_a), 32'(e_da));
        check("done_b", 32'(done_b), 32'(e_db));
        check("err", 32'(err), 32'(e_er));

        if (valid_a && ready_a) begin
          acc_a = cyc; en_cnt = 0; busy_gap = 0; in_cmd = 1'b1;
        end else if (valid_b && ready_b) begin
          acc_b = cyc; en_cnt = 0; busy_gap = 0; in_cmd = 1'b1;
        end else if (in_cmd) begin
          if (!busy) busy_gap++;
          if (cnt_en) begin
            en_cnt++; en_d = d_in; en_ld = load; en_up = inc;
          end
          if (done_a) begin dn_a = cyc; dn_err = err; in_cmd = 1'b0; end
          if (done_b) begin dn_b = cyc; dn_err = err; in_cmd = 1'b0; end
        end
      end
    end
  end

  // Stimulus: inputs change only on the falling edge; an accepted valid drops one cycle later.
  bit drop_a = 1'b0, drop_b = 1'b0;

  task automatic step(input int n);
    repeat (n) begin
      #3;
      drop_a = valid_a & ready_a;
      drop_b = valid_b & ready_b;
      @(negedge clk);
      if (drop_a) valid_a = 1'b0;
      if (drop_b) valid_b = 1'b0;
    end
  endtask

  task automatic req_a(input logic [1:0] c, input logic [7:0] a);
    valid_a = 1'b1; cmd_a = c; arg_a = a;
  endtask

  task automatic req_b(input logic [1:0] c, input logic [7:0] a);
    valid_b = 1'b1; cmd_b = c; arg_b = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    valid_a = 1'b1;
    #3;
    check("lit_rst_ready_a", 32'(ready_a), 32'd0);
    check("lit_rst_d_in", 32'(d_in), 32'd0);
    valid_a = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(2);

    // B alone: ready follows valid; UP by 3
    req_b(2'b01, 8'h03);
    #1;
    check("lit_ready_b_follows", 32'(ready_b), 32'd1);
    check("lit_ready_a_idle", 32'(ready_a), 32'd0);
    step(8);
    check("lit_up3_pulses", 32'(en_cnt), 32'd3);
    check("lit_up3_done_lat", 32'(dn_b - acc_b), 32'd4);
    check("lit_up3_busy_gap", 32'(busy_gap), 32'd0);
    check("lit_up3_inc", 32'(en_up), 32'd1);
    check("lit_up3_load", 32'(en_ld), 32'd0);
    check("lit_up3_err", 32'(dn_err), 32'd0);

    // A LOAD 5A
    req_a(2'b00, 8'h5A);
    step(6);
    check("lit_load_pulses", 32'(en_cnt), 32'd1);
    check("lit_load_d_in", 32'(en_d), 32'h5A);
    check("lit_load_sel", 32'(en_ld), 32'd1);
    check("lit_load_done_lat", 32'(dn_a - acc_a), 32'd2);

    // A UP N=0, then reserved
    req_a(2'b01, 8'hF0);
    step(5);
    check("lit_n0_pulses", 32'(en_cnt), 32'd0);
    check("lit_n0_done_lat", 32'(dn_a - acc_a), 32'd2);
    check("lit_n0_err", 32'(dn_err), 32'd0);
    req_a(2'b11, 8'h03);
    step(5);
    check("lit_rsv_pulses", 32'(en_cnt), 32'd0);
    check("lit_rsv_done_lat", 32'(dn_a - acc_a), 32'd2);
    check("lit_rsv_err", 32'(dn_err), 32'd1);

    // reset in the middle of a long UP
    req_a(2'b01, 8'h09);
    step(4);
    #3;
    reset_n = 1'b0;
    #1;
    check("lit_midrst_cnt_en", 32'(cnt_en), 32'd0);
    check("lit_midrst_busy", 32'(busy), 32'd0);
    check("lit_midrst_inc", 32'(inc), 32'd0);
    check("lit_midrst_done_a", 32'(done_a), 32'd0);
    @(negedge clk);
    req_a(2'b10, 8'h02);
    req_b(2'b00, 8'h10);
    step(2);
    reset_n = 1'b1;
    #1;
    check("lit_both_ready_a", 32'(ready_a), 32'd1);
    check("lit_both_ready_b", 32'(ready_b), 32'd0);
    step(12);
    check("lit_rr1_order", 32'(acc_b - acc_a), 32'd4);
    check("lit_rr1_a_done", 32'(dn_a - acc_a), 32'd3);
    check("lit_rr1_b_done", 32'(dn_b - acc_b), 32'd2);
    check("lit_rr1_b_d_in", 32'(d_in), 32'h10);

    // both valid again: A, then B
    req_a(2'b00, 8'h33);
    req_b(2'b10, 8'h01);
    step(12);
    check("lit_rr2_order", 32'(acc_b - acc_a), 32'd3);
    check("lit_rr2_b_done", 32'(dn_b - acc_b), 32'd2);

`ifdef CNT_SEQ_ABORT_EN
    req_b(2'b10, 8'h0A);
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(10);
    check("lit_abort_pulses", 32'(en_cnt), 32'd4);
    check("lit_abort_done_lat", 32'(dn_b - acc_b), 32'd5);
    check("lit_abort_err", 32'(dn_err), 32'd1);
`endif

    check("lit_requests_drained", 32'(valid_a | valid_b), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
